cutelock_key_scheduler: RTL and testbench

Time-multiplexed key sequencer for Cute-Lock locked cores. Holds NUM_KEYS key words loaded over a valid/ready configuration port. In RUN it presents one word per cycle on the core's key inputs, in lockstep with the core's internal free-running mod-NUM_KEYS state counter. It owns the core's reset, so both counters start at phase 0 on the same clock edge.

---
 rtl/cutelock_pkg.sv | 19 +
 rtl/cutelock_phase_ctr.sv | 30 +++
 rtl/cutelock_key_scheduler.sv | 155 +++++++++++++++
 tb/tb_cutelock_key_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cutelock_pkg.sv
// Shared types and constants for the Cute-Lock key scheduler slice.
package cutelock_pkg;

    localparam int unsigned KEY_W_DEF    = 3;
    localparam int unsigned NUM_KEYS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    // XOR-reduce; zero-extension of narrower words leaves the result unchanged.
    function automatic logic parity32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/cutelock_phase_ctr.sv
// Wrapping CNT_W-bit phase counter with synchronous clear and enable.
module cutelock_phase_ctr #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt_c
);

    always_comb begin
        count_nxt_c = count;
        if (clear) begin
            count_nxt_c = '0;
        end else if (en) begin
            count_nxt_c = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_nxt_c;
        end
    end

endmodule

// File: rtl/cutelock_key_scheduler.sv
// Time-multiplexed key sequencer driving a Cute-Lock core's key inputs and reset.
// Optional even-parity check on config words: define KEYSCHED_PARITY_EN.
module cutelock_key_scheduler
    import cutelock_pkg::*;
#(
    parameter int unsigned KEY_W    = KEY_W_DEF,
    parameter int unsigned NUM_KEYS = NUM_KEYS_DEF,
    parameter int unsigned CNT_W    = $clog2(NUM_KEYS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_idx,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic             cfg_last,
    input  logic             run_req,
    input  logic             clear_req,
    output logic             core_rst_n,
    output logic [KEY_W-1:0] key_out,
    output logic [CNT_W-1:0] phase,
    output logic             armed,
    output logic             running,
    output logic             load_err
`ifdef KEYSCHED_PARITY_EN
    ,
    input  logic             cfg_par,
    output logic             par_err
`endif
);

    state_t                state, state_nxt;
    logic [KEY_W-1:0]      mem [NUM_KEYS];
    logic [NUM_KEYS-1:0]   mask, mask_nxt, mask_upd_c;
    logic                  acc_c, word_ok_c, wr_c, full_c;
    logic                  load_err_nxt;
    logic                  ctr_clear_c, ctr_en_c;
    logic [CNT_W-1:0]      phase_nxt_c;

`ifdef KEYSCHED_PARITY_EN
    logic par_err_nxt;
    assign word_ok_c = ~parity32(32'({cfg_key, cfg_par}));
`else
    assign word_ok_c = 1'b1;
`endif

    assign acc_c      = cfg_valid & cfg_ready;
    assign wr_c       = acc_c & word_ok_c & ~clear_req;
    assign mask_upd_c = mask | (wr_c ? (NUM_KEYS'(1) << cfg_idx) : '0);
    assign full_c     = &mask_upd_c;

    // Next state, mask and sticky error flags; clear_req overrides everything.
    always_comb begin
        state_nxt    = state;
        mask_nxt     = mask;
        load_err_nxt = load_err;
        if (wr_c) begin
            mask_nxt = mask_upd_c;
        end
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (acc_c) begin
                    if (state == ST_IDLE) begin
                        load_err_nxt = 1'b0;
                    end
                    state_nxt = ST_LOAD;
                    if (cfg_last) begin
                        if (full_c) begin
                            state_nxt = ST_ARMED;
                        end else begin
                            state_nxt    = ST_IDLE;
                            mask_nxt     = '0;
                            load_err_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_ARMED: if (run_req)  state_nxt = ST_ARMED == ST_ARMED ? ST_RUN : ST_RUN;
            ST_RUN:   if (!run_req) state_nxt = ST_ARMED;
            default:  state_nxt = ST_IDLE;
        endcase
        if (clear_req) begin
            state_nxt    = ST_IDLE;
            mask_nxt     = '0;
            load_err_nxt = load_err;
        end
`ifdef KEYSCHED_PARITY_EN
        par_err_nxt = par_err | (acc_c & ~word_ok_c & ~clear_req);
`endif
        ctr_clear_c = (state_nxt != ST_RUN);
        ctr_en_c    = (state == ST_RUN);
    end

    cutelock_phase_ctr #(.CNT_W(CNT_W)) u_phase_ctr (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (ctr_clear_c),
        .en          (ctr_en_c),
        .count       (phase),
        .count_nxt_c (phase_nxt_c)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mask       <= '0;
            load_err   <= 1'b0;
            cfg_ready  <= 1'b1;
            core_rst_n <= 1'b0;
            armed      <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            mask       <= mask_nxt;
            load_err   <= load_err_nxt;
            cfg_ready  <= (state_nxt == ST_IDLE) || (state_nxt == ST_LOAD);
            core_rst_n <= (state_nxt == ST_RUN);
            armed      <= (state_nxt == ST_ARMED) || (state_nxt == ST_RUN);
            running    <= (state_nxt == ST_RUN);
        end
    end

`ifdef KEYSCHED_PARITY_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= par_err_nxt;
        end
    end
`endif

    // Key word is looked up with the same next-phase value the counter loads,
    // so key_out and phase always move together.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            key_out <= '0;
        end else if (state_nxt == ST_RUN) begin
            key_out <= mem[phase_nxt_c];
        end else begin
            key_out <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clear_req) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                mem[CNT_W'(i)] <= '0;
            end
        end else if (wr_c) begin
            mem[cfg_idx] <= cfg_key;
        end
    end

endmodule

// File: tb/tb_cutelock_key_scheduler.sv
// Table-driven directed bench for cutelock_key_scheduler (optionally KEYSCHED_PARITY_EN).
module tb_cutelock_key_scheduler;

    localparam int unsigned KEY_W    = 3;
    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned CNT_W    = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_idx;
    logic [KEY_W-1:0] cfg_key;
    logic             cfg_last;
    logic             run_req;
    logic             clear_req;
    logic             core_rst_n;
    logic [KEY_W-1:0] key_out;
    logic [CNT_W-1:0] phase;
    logic             armed;
    logic             running;
    logic             load_err;
`ifdef KEYSCHED_PARITY_EN
    logic             cfg_par;
    logic             par_err;
`endif

    always #5 clock = ~clock;

    cutelock_key_scheduler #(
        .KEY_W    (KEY_W),
        .NUM_KEYS (NUM_KEYS),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_key    (cfg_key),
        .cfg_last   (cfg_last),
        .run_req    (run_req),
        .clear_req  (clear_req),
        .core_rst_n (core_rst_n),
        .key_out    (key_out),
        .phase      (phase),
        .armed      (armed),
        .running    (running),
        .load_err   (load_err)
`ifdef KEYSCHED_PARITY_EN
        ,
        .cfg_par    (cfg_par),
        .par_err    (par_err)
`endif
    );

    typedef struct {
        string      nm;
        logic       v;
        logic [1:0] idx;
        logic [2:0] key;
        logic       last;
        logic       run;
        logic       clr;
        logic       rdy;
        logic       crst;
        logic [2:0] ko;
        logic [1:0] ph;
        logic       arm;
        logic       rn;
        logic       err;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [2:0] keys [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic rdy, input logic crst,
                           input logic [2:0] ko, input logic [1:0] ph,
                           input logic arm, input logic rn, input logic err);
        chk({nm, ".cfg_ready"},  32'(cfg_ready),  32'(rdy));
        chk({nm, ".core_rst_n"}, 32'(core_rst_n), 32'(crst));
        chk({nm, ".key_out"},    32'(key_out),    32'(ko));
        chk({nm, ".phase"},      32'(phase),      32'(ph));
        chk({nm, ".armed"},      32'(armed),      32'(arm));
        chk({nm, ".running"},    32'(running),    32'(rn));
        chk({nm, ".load_err"},   32'(load_err),   32'(err));
    endtask

    task automatic drive(input logic v, input logic [1:0] idx, input logic [2:0] key,
                         input logic last, input logic run, input logic clr);
        cfg_valid = v;
        cfg_idx   = idx;
        cfg_key   = key;
        cfg_last  = last;
        run_req   = run;
        clear_req = clr;
`ifdef KEYSCHED_PARITY_EN
        cfg_par   = ^key;
`endif
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input string nm, input logic v, input logic [1:0] idx,
                       input logic [2:0] key, input logic last, input logic run,
                       input logic clr, input logic rdy, input logic crst,
                       input logic [2:0] ko, input logic [1:0] ph, input logic arm,
                       input logic rn, input logic err);
        vec_t e;
        e = '{nm, v, idx, key, last, run, clr, rdy, crst, ko, ph, arm, rn, err};
        tbl.push_back(e);
    endtask

    initial begin
        keys[0] = 3'b101; keys[1] = 3'b010; keys[2] = 3'b111; keys[3] = 3'b001;

        // Main flow: load, arm, run/wrap, drop/resume, clear, error bursts, reload.
        add("load0", 1, 0, 3'b101, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("load1", 1, 1, 3'b010, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("load2", 1, 2, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("load3", 1, 3, 3'b001, 1, 0, 0,  0, 0, 3'b000, 0, 1, 0, 0);
        add("hold",  0, 0, 3'b000, 0, 0, 0,  0, 0, 3'b000, 0, 1, 0, 0);
        for (int k = 0; k < 11; k++) begin
            add($sformatf("run%0d", k), 0, 0, 3'b000, 0, 1, 0,
                0, 1, keys[k % 4], 2'(k % 4), 1, 1, 0);
        end
        add("drop",     0, 0, 3'b000, 0, 0, 0,  0, 0, 3'b000, 0, 1, 0, 0);
        add("resume0",  0, 0, 3'b000, 0, 1, 0,  0, 1, 3'b101, 0, 1, 1, 0);
        add("resume1",  0, 0, 3'b000, 0, 1, 0,  0, 1, 3'b010, 1, 1, 1, 0);
        add("drop2",    0, 0, 3'b000, 0, 0, 0,  0, 0, 3'b000, 0, 1, 0, 0);
        add("clr_run",  0, 0, 3'b000, 0, 1, 1,  1, 0, 3'b000, 0, 0, 0, 0);
        add("single",   1, 0, 3'b110, 1, 0, 0,  1, 0, 3'b000, 0, 0, 0, 1);
        add("err_b0",   1, 0, 3'b011, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("err_b1",   1, 1, 3'b100, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("err_b3",   1, 3, 3'b010, 1, 0, 0,  1, 0, 3'b000, 0, 0, 0, 1);
        add("rl0",      1, 0, 3'b101, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("rl1",      1, 1, 3'b010, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("rl2a",     1, 2, 3'b000, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("rl2b",     1, 2, 3'b111, 0, 0, 0,  1, 0, 3'b000, 0, 0, 0, 0);
        add("rl3",      1, 3, 3'b001, 1, 0, 0,  0, 0, 3'b000, 0, 1, 0, 0);
        add("armed_wr", 1, 2, 3'b000, 0, 0, 0,  0, 0, 3'b000, 0, 1, 0, 0);
        add("go0",      0, 0, 3'b000, 0, 1, 0,  0, 1, 3'b101, 0, 1, 1, 0);
        add("go1",      0, 0, 3'b000, 0, 1, 0,  0, 1, 3'b010, 1, 1, 1, 0);
        add("go2",      0, 0, 3'b000, 0, 1, 0,  0, 1, 3'b111, 2, 1, 1, 0);

        reset_n = 1'b0;
        drive(0, 0, 3'b000, 0, 0, 0);
        step();
        step();
        chk_all("reset", 1, 0, 3'b000, 0, 0, 0, 0);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].idx, tbl[i].key, tbl[i].last, tbl[i].run, tbl[i].clr);
            step();
            chk_all(tbl[i].nm, tbl[i].rdy, tbl[i].crst, tbl[i].ko, tbl[i].ph,
                    tbl[i].arm, tbl[i].rn, tbl[i].err);
        end

        // clear_req in RUN drops key_out and core reset on the same edge.
        drive(0, 0, 3'b000, 0, 1, 1);
        step();
        chk_all("clr_mid_run", 1, 0, 3'b000, 0, 0, 0, 0);

        // clear_req beats a same-cycle incomplete cfg_last: no load_err.
        drive(1, 0, 3'b111, 1, 0, 1);
        step();
        chk_all("clr_vs_cfg", 1, 0, 3'b000, 0, 0, 0, 0);

        // Fresh load, run two cycles, then reset_n mid-RUN.
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'(i), 3'(i + 1), (i == 3), 0, 0);
            step();
        end
        chk_all("arm2", 0, 0, 3'b000, 0, 1, 0, 0);
        drive(0, 0, 3'b000, 0, 1, 0);
        step();
        chk_all("arm2_run0", 0, 1, 3'b001, 0, 1, 1, 0);
        step();
        chk_all("arm2_run1", 0, 1, 3'b010, 1, 1, 1, 0);
        reset_n = 1'b0;
        step();
        chk_all("rst_mid_run", 1, 0, 3'b000, 0, 0, 0, 0);
        reset_n = 1'b1;
        step();
        chk_all("post_rst_run", 1, 0, 3'b000, 0, 0, 0, 0);

`ifdef KEYSCHED_PARITY_EN
        // Bad-parity word on slot 2 is consumed but not written.
        drive(0, 0, 3'b000, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'(i), keys[i], (i == 3), 0, 0);
            if (i == 2) cfg_par = 1'b0;
            step();
            if (i == 2) chk("par_bad.par_err", 32'(par_err), 32'd1);
            if (i == 1) chk("par_ok.par_err", 32'(par_err), 32'd0);
        end
        chk_all("par_last", 1, 0, 3'b000, 0, 0, 0, 1);
`endif

        drive(0, 0, 3'b000, 0, 0, 0);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
